// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator core: run sequencer state encoding
// and the program counter geometry used by PC, PC_LUT and run_sequencer.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        STEP,
        DONE,
        ERR
    } seq_state_t;

    localparam int unsigned PC_WIDTH       = 12;
    localparam int unsigned END_PC_DEFAULT = 128;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Run controller for the accumulator core: start handshake, core reset window,
// continuous or single-step PC advance, end-of-program detection and watchdog.
module run_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned D       = PC_WIDTH,
    parameter int unsigned END_PC  = END_PC_DEFAULT,
    parameter int unsigned CLR_CYC = 2,
    parameter int unsigned CW      = 16,
    parameter int unsigned TIMEOUT = 4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          step_mode,
    input  logic          step,
    input  logic [D-1:0]  prog_ctr,
    output logic          core_rst,
    output logic          run_en,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] cycles
);

    localparam int unsigned CLR_W = $clog2(CLR_CYC + 1);

    seq_state_t       state;
    logic             stepping;
    logic [CLR_W-1:0] clr_cnt;
    logic             end_hit;
    logic             wd_hit;
    logic             start;

    assign end_hit = (prog_ctr == D'(END_PC));
    assign wd_hit  = run_en && (cycles == CW'(TIMEOUT - 1));
    assign start   = (state == IDLE) && req;

    // A cycle that reaches the end address is not counted as an executed instruction.
    sat_counter #(
        .W(CW)
    ) u_cycles (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .inc   (run_en && !end_hit),
        .count (cycles)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            core_rst <= 1'b1;
            run_en   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            stepping <= 1'b0;
            clr_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    core_rst <= 1'b1;
                    run_en   <= 1'b0;
                    done     <= 1'b0;
                    if (req) begin
                        state    <= CLEAR;
                        stepping <= step_mode;
                        err      <= 1'b0;
                        clr_cnt  <= CLR_W'(CLR_CYC - 1);
                    end
                end
                CLEAR: begin
                    if (clr_cnt == '0) begin
                        core_rst <= 1'b0;
                        state    <= stepping ? STEP : RUN;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                RUN, STEP: begin
                    // End of program wins over the watchdog on the same edge.
                    if (end_hit) begin
                        state  <= DONE;
                        run_en <= 1'b0;
                        done   <= 1'b1;
                    end else if (wd_hit) begin
                        state  <= ERR;
                        run_en <= 1'b0;
                        done   <= 1'b1;
                        err    <= 1'b1;
                    end else if (state == RUN) begin
                        run_en <= 1'b1;
                    end else begin
                        run_en <= !run_en && step;
                    end
                end
                DONE, ERR: begin
                    run_en <= 1'b0;
                    if (!req) begin
                        state    <= IDLE;
                        done     <= 1'b0;
                        core_rst <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    core_rst <= 1'b1;
                    run_en   <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: table of whole-run vectors scored through
// a queue, plus hand-written latency, handshake, back-to-back step and reset sequences.
module tb_run_sequencer;

    localparam int unsigned D  = 12;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          reset;
    logic          req;
    logic          step_mode;
    logic          step;
    logic [D-1:0]  prog_ctr;
    logic          core_rst;
    logic          run_en;
    logic          done;
    logic          err;
    logic [CW-1:0] cycles;

    int unsigned tests;
    int unsigned fails;

    typedef struct {
        bit          step_mode;
        int unsigned n_run;
        int unsigned n_steps;
        int unsigned gap;
        bit          drop_req;
        bit          exp_err;
        int unsigned exp_cycles;
        int unsigned exp_pulses;
    } vec_t;

    typedef struct {
        string       name;
        bit          done;
        bit          err;
        int unsigned cyc;
        int unsigned pulses;
    } exp_t;

    vec_t  vecs[6];
    string names[6];
    exp_t  sb[$];

    run_sequencer #(
        .D       (12),
        .END_PC  (128),
        .CLR_CYC (2),
        .CW      (16),
        .TIMEOUT (4000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .step_mode (step_mode),
        .step      (step),
        .prog_ctr  (prog_ctr),
        .core_rst  (core_rst),
        .run_en    (run_en),
        .done      (done),
        .err       (err),
        .cycles    (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Whole run driven from IDLE; a simple PC model advances prog_ctr after every
    // run_en cycle and presents END_PC once n_run instructions have completed.
    task automatic run_case(input string name, input vec_t v);
        exp_t        e;
        exp_t        got_e;
        int unsigned count;
        bit          prev;
        bit          got_done;

        e.name   = name;
        e.done   = 1'b1;
        e.err    = v.exp_err;
        e.cyc    = v.exp_cycles;
        e.pulses = v.exp_pulses;
        sb.push_back(e);

        count     = 0;
        prev      = 1'b0;
        got_done  = 1'b0;
        prog_ctr  = (v.n_run == 0) ? 12'd128 : 12'd0;
        step_mode = v.step_mode;
        step      = 1'b0;
        req       = 1'b1;

        for (int unsigned t = 1; t <= 4200; t++) begin
            tick();
            step = 1'b0;
            if (prev) begin
                count++;
                prog_ctr = (count == v.n_run) ? 12'd128 : 12'(count % 100);
            end
            prev = run_en;
            if (t == 2 && v.drop_req) req = 1'b0;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (v.step_mode && t >= 4 && ((t - 4) % v.gap) == 0 && ((t - 4) / v.gap) < v.n_steps)
                step = 1'b1;
        end

        got_e = sb.pop_front();
        check({got_e.name, "_done"},   32'(got_done), 32'(got_e.done));
        check({got_e.name, "_err"},    32'(err),      32'(got_e.err));
        check({got_e.name, "_cycles"}, 32'(cycles),   got_e.cyc);
        check({got_e.name, "_pulses"}, count,         got_e.pulses);

        req = 1'b0;
        tick();
        tick();
        check({got_e.name, "_idle_done"}, 32'(done),   32'd0);
        check({got_e.name, "_cyc_hold"},  32'(cycles), got_e.cyc);
    endtask

    initial begin
        int unsigned bad;
        int unsigned pulses;

        tests     = 0;
        fails     = 0;
        reset     = 1'b0;
        req       = 1'b0;
        step_mode = 1'b0;
        step      = 1'b0;
        prog_ctr  = '0;

        //            step n_run n_st gap drop err cyc   pulses
        vecs[0] = '{1'b0,   40,   0,   1, 1'b0, 1'b0,   40,   41};
        names[0] = "end40";
        vecs[1] = '{1'b0,    1,   0,   1, 1'b1, 1'b0,    1,    2};
        names[1] = "end1_drop";
        vecs[2] = '{1'b0,    0,   0,   1, 1'b0, 1'b0,    0,    0};
        names[2] = "end_at_start";
        vecs[3] = '{1'b0, 5000,   0,   1, 1'b0, 1'b1, 4000, 4000};
        names[3] = "watchdog";
        vecs[4] = '{1'b0, 3999,   0,   1, 1'b0, 1'b0, 3999, 4000};
        names[4] = "end_vs_wd";
        vecs[5] = '{1'b1,    3,   3,   5, 1'b0, 1'b0,    3,    3};
        names[5] = "step3";

        tick();
        tick();
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_run_en",   32'(run_en),   32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_cycles",   32'(cycles),   32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_case(names[i], vecs[i]);

        // Start latency and the req/done handshake.
        step_mode = 1'b0;
        prog_ctr  = '0;
        req       = 1'b1;
        tick();
        check("lat_e1_core_rst", 32'(core_rst), 32'd1);
        check("lat_e1_cycles",   32'(cycles),   32'd0);
        tick();
        check("lat_e2_core_rst", 32'(core_rst), 32'd1);
        check("lat_e2_run_en",   32'(run_en),   32'd0);
        tick();
        check("lat_e3_core_rst", 32'(core_rst), 32'd0);
        check("lat_e3_run_en",   32'(run_en),   32'd0);
        tick();
        check("lat_e4_run_en",   32'(run_en),   32'd1);
        tick();
        tick();
        tick();
        prog_ctr = 12'd128;
        tick();
        check("hs_done",   32'(done),   32'd1);
        check("hs_run_en", 32'(run_en), 32'd0);
        check("hs_cycles", 32'(cycles), 32'd3);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done !== 1'b1 || run_en !== 1'b0 || core_rst !== 1'b0) bad++;
        end
        check("hs_no_restart", bad, 32'd0);
        req = 1'b0;
        tick();
        check("hs_idle_done",     32'(done),     32'd0);
        check("hs_idle_core_rst", 32'(core_rst), 32'd1);

        // Back-to-back step pulses give one run_en cycle.
        prog_ctr  = '0;
        step_mode = 1'b1;
        req       = 1'b1;
        tick();
        tick();
        tick();
        tick();
        pulses = 0;
        step   = 1'b1;
        tick();
        pulses += 32'(run_en);
        tick();
        step   = 1'b0;
        pulses += 32'(run_en);
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += 32'(run_en);
        end
        check("b2b_pulses", pulses, 32'd1);
        check("b2b_cycles", 32'(cycles), 32'd1);
        req   = 1'b0;
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        tick();

        // Asynchronous reset in the middle of a continuous run.
        step_mode = 1'b0;
        req       = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("mid_run_en_before", 32'(run_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_core_rst", 32'(core_rst), 32'd1);
        check("mid_run_en",   32'(run_en),   32'd0);
        check("mid_done",     32'(done),     32'd0);
        check("mid_cycles",   32'(cycles),   32'd0);
        req = 1'b0;
        #3 reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (core_rst !== 1'b1 || run_en !== 1'b0 || done !== 1'b0) bad++;
        end
        check("post_rst_idle", bad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
